// File: rtl/noc_params.sv
// Shared NoC router parameters and port encoding.
package noc_params;

    localparam int PORT_NUM    = 5;
    localparam int VC_NUM      = 2;
    localparam int VC_SIZE     = $clog2(VC_NUM);
    localparam int BUFFER_SIZE = 8;
    localparam int PORT_SIZE   = $clog2(PORT_NUM);
    localparam int CRED_W      = $clog2(BUFFER_SIZE + 1);

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL, NORTH, SOUTH, WEST, EAST
    } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick starting at ptr; pointer state lives in the caller.
module round_robin_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sa_credit_allocator.sv
// Separable input-first switch allocator with per-downstream-VC credit counters.
module sa_credit_allocator
    import noc_params::*;
(
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]           switch_request,
    input  port_t [PORT_NUM-1:0][VC_NUM-1:0]           out_port,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc,
    input  logic  [PORT_NUM-1:0]                       credit_valid,
    input  logic  [PORT_NUM-1:0][VC_SIZE-1:0]          credit_vc,
    output logic  [PORT_NUM-1:0][VC_SIZE-1:0]          vc_sel,
    output logic  [PORT_NUM-1:0]                       valid_sel,
    output logic  [PORT_NUM-1:0][PORT_SIZE-1:0]        xb_sel,
    output logic  [PORT_NUM-1:0]                       xb_valid,
    output logic                                       credit_err
);

    logic [CRED_W-1:0] credit_q [PORT_NUM][VC_NUM];
    logic [CRED_W-1:0] credit_d [PORT_NUM][VC_NUM];
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   in_ptr_q, in_ptr_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_ptr_q, out_ptr_d;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel_q, vc_sel_d;
    logic [PORT_NUM-1:0]                valid_sel_q, valid_sel_d;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel_q, xb_sel_d;
    logic [PORT_NUM-1:0]                xb_valid_q, xb_valid_d;
    logic                               credit_err_q, credit_err_d;

    logic [PORT_NUM-1:0][VC_NUM-1:0]    elig, s1_gnt;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   s1_idx;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] s1_port;
    logic [PORT_NUM-1:0]                s1_valid;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  out_req, out_gnt;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_idx;
    logic [PORT_NUM-1:0]                out_valid, in_grant;
    logic [PORT_NUM-1:0][VC_NUM-1:0]    cred_inc, cred_dec;

    // Eligibility looks only at registered credits.
    always_comb begin
        elig = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                elig[i][v] = switch_request[i][v]
                    && (int'(out_port[i][v]) < PORT_NUM)
                    && (credit_q[out_port[i][v]][downstream_vc[i][v]] != '0);
            end
        end
    end

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
        round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
            .req (elig[i]),
            .ptr (in_ptr_q[i]),
            .gnt (s1_gnt[i]),
            .idx (s1_idx[i])
        );
    end

    always_comb begin
        s1_valid = '0;
        s1_port  = '0;
        out_req  = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            s1_valid[i] = |s1_gnt[i];
            s1_port[i]  = out_port[i][s1_idx[i]];
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                out_req[o][i] = s1_valid[i] && (s1_port[i] == PORT_SIZE'(o));
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
        round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
            .req (out_req[o]),
            .ptr (out_ptr_q[o]),
            .gnt (out_gnt[o]),
            .idx (out_idx[o])
        );
    end

    always_comb begin
        out_valid = '0;
        in_grant  = '0;
        cred_inc  = '0;
        cred_dec  = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            out_valid[o] = |out_gnt[o];
            in_grant     = in_grant | out_gnt[o];
            for (int v = 0; v < VC_NUM; v++) begin
                cred_dec[o][v] = out_valid[o] && (downstream_vc[out_idx[o]]
                    [s1_idx[out_idx[o]]] == VC_SIZE'(v));
                cred_inc[o][v] = credit_valid[o]
                    && (credit_vc[o] == VC_SIZE'(v));
            end
        end
    end

    always_comb begin
        vc_sel_d     = vc_sel_q;
        valid_sel_d  = in_grant;
        xb_sel_d     = xb_sel_q;
        xb_valid_d   = out_valid;
        in_ptr_d     = in_ptr_q;
        out_ptr_d    = out_ptr_q;
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (in_grant[i]) begin
                vc_sel_d[i] = s1_idx[i];
                in_ptr_d[i] = VC_SIZE'((int'(s1_idx[i]) + 1) % VC_NUM);
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            if (out_valid[o]) begin
                xb_sel_d[o]  = out_idx[o];
                out_ptr_d[o] = PORT_SIZE'((int'(out_idx[o]) + 1) % PORT_NUM);
            end
            for (int v = 0; v < VC_NUM; v++) begin
                if (cred_inc[o][v] && !cred_dec[o][v]) begin
                    if (credit_q[o][v] == CRED_W'(BUFFER_SIZE))
                        credit_err_d = 1'b1;
                    else
                        credit_d[o][v] = credit_q[o][v] + 1'b1;
                end else if (cred_dec[o][v] && !cred_inc[o][v]) begin
                    credit_d[o][v] = credit_q[o][v] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vc_sel_q     <= '0;
            valid_sel_q  <= '0;
            xb_sel_q     <= '0;
            xb_valid_q   <= '0;
            in_ptr_q     <= '0;
            out_ptr_q    <= '0;
            credit_err_q <= 1'b0;
            for (int o = 0; o < PORT_NUM; o++)
                for (int v = 0; v < VC_NUM; v++)
                    credit_q[o][v] <= CRED_W'(BUFFER_SIZE);
        end else begin
            vc_sel_q     <= vc_sel_d;
            valid_sel_q  <= valid_sel_d;
            xb_sel_q     <= xb_sel_d;
            xb_valid_q   <= xb_valid_d;
            in_ptr_q     <= in_ptr_d;
            out_ptr_q    <= out_ptr_d;
            credit_err_q <= credit_err_d;
            credit_q     <= credit_d;
        end
    end

    assign vc_sel     = vc_sel_q;
    assign valid_sel  = valid_sel_q;
    assign xb_sel     = xb_sel_q;
    assign xb_valid   = xb_valid_q;
    assign credit_err = credit_err_q;

endmodule

// File: tb/tb_sa_credit_allocator.sv
// Directed bench for sa_credit_allocator: table vectors plus multi-cycle sequences.
module tb_sa_credit_allocator;
    import noc_params::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic  [PORT_NUM-1:0][VC_NUM-1:0]              sreq;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              op;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] dv;
    logic  [PORT_NUM-1:0]                          cval;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]             cvc;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel;
    logic  [PORT_NUM-1:0]                          valid_sel;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0]           xb_sel;
    logic  [PORT_NUM-1:0]                          xb_valid;
    logic                                          credit_err;

    sa_credit_allocator dut (
        .clk            (clk),
        .rst            (rst),
        .switch_request (sreq),
        .out_port       (op),
        .downstream_vc  (dv),
        .credit_valid   (cval),
        .credit_vc      (cvc),
        .vc_sel         (vc_sel),
        .valid_sel      (valid_sel),
        .xb_sel         (xb_sel),
        .xb_valid       (xb_valid),
        .credit_err     (credit_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        sreq = '0;
        dv   = '0;
        cval = '0;
        cvc  = '0;
        for (int i = 0; i < PORT_NUM; i++)
            for (int v = 0; v < VC_NUM; v++)
                op[i][v] = LOCAL;
    endtask

    task automatic req(input int i, input int v, input int o, input int d);
        sreq[i][v] = 1'b1;
        op[i][v]   = port_t'(o);
        dv[i][v]   = VC_SIZE'(d);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    typedef struct packed {
        logic [9:0]      rq;
        logic [9:0][2:0] po;
        logic [9:0]      dvc;
        logic [4:0]      ev;
        logic [4:0]      evc;
        logic [4:0]      exv;
        logic [4:0][2:0] exs;
    } vec_t;

    function automatic vec_t vr(input vec_t t, input int i, input int v,
                                input int o, input int d);
        vec_t r;
        int k;
        r = t;
        k = i * 2 + v;
        r.rq[k]  = 1'b1;
        r.po[k]  = 3'(o);
        r.dvc[k] = 1'(d);
        return r;
    endfunction

    vec_t tv [7];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w [4];
        clr();

        // each vector starts from reset: pointers 0, credits full
        tv[0] = '0;
        tv[1] = vr('0, 0, 1, 4, 0);
        tv[1].ev = 5'b00001; tv[1].evc = 5'b00001;
        tv[1].exv = 5'b10000; tv[1].exs[4] = 3'd0;
        tv[2] = vr(vr('0, 2, 0, 0, 0), 3, 1, 3, 1);
        tv[2].ev = 5'b01100; tv[2].evc = 5'b01000;
        tv[2].exv = 5'b01001; tv[2].exs[0] = 3'd2; tv[2].exs[3] = 3'd3;
        tv[3] = vr(vr('0, 1, 0, 1, 0), 4, 0, 1, 1);
        tv[3].ev = 5'b00010; tv[3].evc = 5'b00000;
        tv[3].exv = 5'b00010; tv[3].exs[1] = 3'd1;
        tv[4] = vr(vr('0, 3, 0, 2, 0), 3, 1, 4, 0);
        tv[4].ev = 5'b01000; tv[4].evc = 5'b00000;
        tv[4].exv = 5'b00100; tv[4].exs[2] = 3'd3;
        tv[5] = '0;
        for (int i = 0; i < 5; i++) tv[5] = vr(tv[5], i, 1, (i + 1) % 5, 0);
        tv[5].ev = 5'b11111; tv[5].evc = 5'b11111; tv[5].exv = 5'b11111;
        for (int o = 0; o < 5; o++) tv[5].exs[o] = 3'((o + 4) % 5);
        tv[6] = vr(vr('0, 4, 0, 2, 0), 0, 0, 2, 1);
        tv[6].ev = 5'b00001; tv[6].evc = 5'b00000;
        tv[6].exv = 5'b00100; tv[6].exs[2] = 3'd0;

        for (int n = 0; n < 7; n++) begin
            clr();
            do_reset(1);
            for (int i = 0; i < PORT_NUM; i++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    sreq[i][v] = tv[n].rq[i*2+v];
                    op[i][v]   = port_t'(tv[n].po[i*2+v]);
                    dv[i][v]   = tv[n].dvc[i*2+v];
                end
            end
            tick();
            chk($sformatf("vec%0d valid_sel", n), 32'(valid_sel), 32'(tv[n].ev));
            chk($sformatf("vec%0d xb_valid", n), 32'(xb_valid), 32'(tv[n].exv));
            for (int i = 0; i < PORT_NUM; i++)
                if (tv[n].ev[i])
                    chk($sformatf("vec%0d vc_sel[%0d]", n, i),
                        32'(vc_sel[i]), 32'(tv[n].evc[i]));
            for (int o = 0; o < PORT_NUM; o++)
                if (tv[n].exv[o])
                    chk($sformatf("vec%0d xb_sel[%0d]", n, o),
                        32'(xb_sel[o]), 32'(tv[n].exs[o]));
        end

        // reset held 2 cycles with a pending request, then 8 grants to (EAST,0)
        clr();
        req(0, 0, 4, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("rst valid_sel", 32'(valid_sel), 0);
        chk("rst xb_valid", 32'(xb_valid), 0);
        chk("rst credit_err", 32'(credit_err), 0);
        chk("rst vc_sel", 32'(vc_sel), 0);
        chk("rst credit", 32'(dut.credit_q[4][0]), 8);
        rst = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("east0 grant %0d", k), 32'(valid_sel[0]),
                32'(k <= 8));
        end
        chk("east0 credit drained", 32'(dut.credit_q[4][0]), 0);

        // input round robin across two VCs
        clr();
        do_reset(1);
        req(0, 0, 1, 0);
        req(0, 1, 1, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("inrr valid %0d", k), 32'(valid_sel[0]), 1);
            chk($sformatf("inrr vc_sel %0d", k), 32'(vc_sel[0]), 32'(k % 2));
        end

        // output contention on WEST
        clr();
        do_reset(1);
        req(1, 0, 3, 0);
        req(2, 0, 3, 0);
        req(2, 1, 3, 1);
        req(3, 0, 3, 0);
        w = '{1, 2, 3, 1};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("west xb_valid %0d", k), 32'(xb_valid), 32'h08);
            chk($sformatf("west xb_sel %0d", k), 32'(xb_sel[3]), 32'(w[k]));
            chk($sformatf("west valid_sel %0d", k), 32'(valid_sel),
                32'(1 << w[k]));
            if (k == 0) begin
                chk("loser in_ptr[2]", 32'(dut.in_ptr_q[2]), 0);
                chk("loser in_ptr[3]", 32'(dut.in_ptr_q[3]), 0);
            end
            if (k == 1)
                chk("loser retries vc0", 32'(vc_sel[2]), 0);
        end

        // credit exhaustion and return on (SOUTH,1)
        clr();
        do_reset(1);
        req(1, 1, 2, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("south1 grant %0d", k), 32'(valid_sel[1]), 1);
        end
        tick();
        chk("south1 blocked", 32'(valid_sel[1]), 0);
        cval[2] = 1'b1;
        cvc[2]  = 1'b1;
        tick();
        chk("south1 no grant at return", 32'(valid_sel[1]), 0);
        chk("south1 credit 1", 32'(dut.credit_q[2][1]), 1);
        cval = '0;
        tick();
        chk("south1 grant after return", 32'(valid_sel[1]), 1);
        chk("south1 credit 0", 32'(dut.credit_q[2][1]), 0);

        // grant and return in the same cycle at credit 1
        cval[2] = 1'b1;
        tick();
        chk("south1 refill no grant", 32'(valid_sel[1]), 0);
        tick();
        chk("south1 simul grant", 32'(valid_sel[1]), 1);
        chk("south1 simul credit", 32'(dut.credit_q[2][1]), 1);
        clr();
        tick();
        chk("south1 credit held", 32'(dut.credit_q[2][1]), 1);
        chk("no err yet", 32'(credit_err), 0);

        // return into a full counter
        cval[4] = 1'b1;
        cvc[4]  = 1'b0;
        tick();
        chk("overflow err", 32'(credit_err), 1);
        chk("overflow credit held", 32'(dut.credit_q[4][0]), 8);
        cval = '0;
        repeat (3) tick();
        chk("err sticky", 32'(credit_err), 1);
        do_reset(1);
        chk("err cleared", 32'(credit_err), 0);

        // reset mid-stream
        clr();
        do_reset(1);
        req(0, 0, 4, 0);
        req(4, 1, 0, 1);
        repeat (3) tick();
        chk("stream valid", 32'(valid_sel), 32'h11);
        rst = 1'b0;
        tick();
        chk("midrst valid_sel", 32'(valid_sel), 0);
        chk("midrst xb_valid", 32'(xb_valid), 0);
        for (int o = 0; o < PORT_NUM; o++)
            for (int v = 0; v < VC_NUM; v++)
                chk($sformatf("midrst credit[%0d][%0d]", o, v),
                    32'(dut.credit_q[o][v]), 8);
        rst = 1'b1;
        tick();
        chk("resume valid", 32'(valid_sel), 32'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
